// File: rtl/nand_seq_pkg.sv
// Shared types and op-word layout for the NAND sequencer.
package nand_seq_pkg;

  localparam int NUM_REGS_DEF = 16;
  localparam int NUM_OPS_DEF  = 32;
  localparam int NUM_IN_DEF   = 4;
  localparam int NUM_OUT_DEF  = 4;
  localparam int IDX_W_DEF    = $clog2(NUM_REGS_DEF);
  localparam int PC_W_DEF     = $clog2(NUM_OPS_DEF);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXEC,
    S_DONE
  } state_e;

  // Op word is {dst, src_b, src_a} with src_a in the LSBs.
  function automatic int op_src_a_lsb(input int idx_w);
    return 0;
  endfunction

  function automatic int op_src_b_lsb(input int idx_w);
    return idx_w;
  endfunction

  function automatic int op_dst_lsb(input int idx_w);
    return 2 * idx_w;
  endfunction

  localparam int OP_SRC_A_LSB = op_src_a_lsb(IDX_W_DEF);
  localparam int OP_SRC_B_LSB = op_src_b_lsb(IDX_W_DEF);
  localparam int OP_DST_LSB   = op_dst_lsb(IDX_W_DEF);

endpackage

// File: rtl/nand_seq_ctrl_if.sv
// Program-load / run / result bundle between a host and nand_seq_ctrl.
interface nand_seq_ctrl_if #(
  parameter int IDX_W   = 4,
  parameter int PC_W    = 5,
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4
);
  logic                 prog_we;
  logic [PC_W-1:0]      prog_addr;
  logic [3*IDX_W-1:0]   prog_data;
  logic [PC_W:0]        prog_len;
  logic                 start;
  logic [NUM_IN-1:0]    in_bits;
  logic                 busy;
  logic                 done;
  logic [NUM_OUT-1:0]   out_bits;
  logic                 prog_err;

  modport master (
    output prog_we, prog_addr, prog_data, prog_len, start, in_bits,
    input  busy, done, out_bits, prog_err
  );

  modport slave (
    input  prog_we, prog_addr, prog_data, prog_len, start, in_bits,
    output busy, done, out_bits, prog_err
  );
endinterface

// File: rtl/nand_seq_ctrl_cell.sv
// The single shared two-input NAND cell used as the sequencer datapath.
module nand_cell (
  input  logic A,
  input  logic B,
  output logic Y
);
  assign Y = ~(A & B);
endmodule

// File: rtl/nand_seq_ctrl.sv
// Sequential evaluator of a stored NAND-only program over a bit register file.
// Optional macro NAND_SEQ_STEP_EN adds a `step` input gating op execution in EXEC.
module nand_seq_ctrl
  import nand_seq_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_OPS  = NUM_OPS_DEF,
  parameter int NUM_IN   = NUM_IN_DEF,
  parameter int NUM_OUT  = NUM_OUT_DEF
) (
  input  logic clk,
  input  logic rst,
`ifdef NAND_SEQ_STEP_EN
  input  logic step,
`endif
  nand_seq_ctrl_if.slave bus
);

  localparam int IDX_W     = $clog2(NUM_REGS);
  localparam int PC_W      = $clog2(NUM_OPS);
  localparam int OP_W      = 3 * IDX_W;
  localparam int SRC_A_LSB = op_src_a_lsb(IDX_W);
  localparam int SRC_B_LSB = op_src_b_lsb(IDX_W);
  localparam int DST_LSB   = op_dst_lsb(IDX_W);

  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);
  localparam logic [PC_W:0]   LEN_ONE = (PC_W+1)'(1);
  localparam logic [PC_W:0]   LEN_MAX = (PC_W+1)'(NUM_OPS);

  state_e                state_q, state_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [PC_W:0]         len_q, len_d;
  logic [NUM_IN-1:0]     in_q, in_d;
  logic [NUM_REGS-1:0]   regs_q, regs_d;
  logic [NUM_OUT-1:0]    out_q, out_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [OP_W-1:0]       prog_mem [NUM_OPS];
  logic [OP_W-1:0]       op_q;
  logic                  prog_wr_en;

  logic [NUM_REGS-1:0]   load_vec;
  logic [IDX_W-1:0]      op_src_a, op_src_b, op_dst;
  logic                  nand_y;
  logic                  exec_en;
  logic                  last_op;

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_load
      if (gi < NUM_IN) begin : g_in
        assign load_vec[gi] = in_q[gi];
      end else begin : g_zero
        assign load_vec[gi] = 1'b0;
      end
    end
  endgenerate

  assign op_src_a = op_q[SRC_A_LSB +: IDX_W];
  assign op_src_b = op_q[SRC_B_LSB +: IDX_W];
  assign op_dst   = op_q[DST_LSB   +: IDX_W];

  nand_cell u_nand (
    .A (regs_q[op_src_a]),
    .B (regs_q[op_src_b]),
    .Y (nand_y)
  );

`ifdef NAND_SEQ_STEP_EN
  assign exec_en = step;
`else
  assign exec_en = 1'b1;
`endif

  assign last_op = ({1'b0, pc_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    len_d      = len_q;
    in_d       = in_q;
    regs_d     = regs_q;
    out_d      = out_q;
    done_d     = 1'b0;
    err_d      = err_q;
    prog_wr_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        prog_wr_en = bus.prog_we;
        if (bus.start) begin
          state_d = S_LOAD;
          len_d   = (bus.prog_len > LEN_MAX) ? LEN_MAX : bus.prog_len;
          in_d    = bus.in_bits;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        regs_d  = load_vec;
        pc_d    = '0;
        state_d = (len_q == '0) ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        if (exec_en) begin
          regs_d[op_dst] = nand_y;
          if (last_op) begin
            state_d = S_DONE;
          end else begin
            pc_d = pc_q + PC_ONE;
          end
        end
      end
      S_DONE: begin
        out_d   = regs_q[NUM_REGS-NUM_OUT +: NUM_OUT];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.prog_we && (state_q != S_IDLE)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      in_q    <= '0;
      regs_q  <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      in_q    <= in_d;
      regs_q  <= regs_d;
      out_q   <= out_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Registered read addressed by pc_d, so op_q always holds the op at pc_q.
  always_ff @(posedge clk) begin
    if (prog_wr_en) begin
      prog_mem[bus.prog_addr] <= bus.prog_data;
    end
    op_q <= prog_mem[pc_d];
  end

  assign bus.busy     = (state_q != S_IDLE);
  assign bus.done     = done_q;
  assign bus.out_bits = out_q;
  assign bus.prog_err = err_q;

endmodule

// File: tb/tb_nand_seq_ctrl.sv
// Scoreboard bench for nand_seq_ctrl: directed programs, expected results queued at start.
module tb_nand_seq_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic step = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic [3:0] out;
    int         cyc;
    string      name;
  } exp_t;

  exp_t sb[$];

  nand_seq_ctrl_if #(.IDX_W(4), .PC_W(5), .NUM_IN(4), .NUM_OUT(4)) bus ();

  nand_seq_ctrl dut (
    .clk  (clk),
    .rst  (rst),
`ifdef NAND_SEQ_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every done pulse is matched against the oldest expected run.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL done_unexpected: got done=1 out_bits=%b at cycle %0d, required no pending run",
                 bus.out_bits, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.out_bits !== e.out || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s: got out_bits=%b at cycle %0d, required out_bits=%b at cycle %0d",
                   e.name, bus.out_bits, cyc, e.out, e.cyc);
        end else begin
          $display("ok   %s: out_bits=%b at cycle %0d", e.name, bus.out_bits, cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, required %b", name, got, want);
    end else begin
      $display("ok   %s: %b", name, got);
    end
  endtask

  task automatic prog_write(input int addr, input int dst, input int src_b, input int src_a);
    @(negedge clk);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[4:0];
    bus.prog_data = {dst[3:0], src_b[3:0], src_a[3:0]};
    @(negedge clk);
    bus.prog_we   = 1'b0;
  endtask

  task automatic run(input logic [3:0] in, input int len, input logic [3:0] exp_out,
                     input string name, input bit push);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.in_bits  = in;
    bus.prog_len = len[5:0];
    if (push) sb.push_back('{exp_out, cyc + len + 3, name});
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit drained = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.busy) begin
        drained = 1'b1;
        break;
      end
    end
    if (!drained) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got %0d runs still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic load_xor();
    prog_write(0, 4, 1, 0);
    prog_write(1, 5, 4, 0);
    prog_write(2, 6, 4, 1);
    prog_write(3, 15, 6, 5);
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
    bus.in_bits   = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_busy", {3'b0, bus.busy}, 4'b0000);
    check("reset_done", {3'b0, bus.done}, 4'b0000);
    check("reset_out_bits", bus.out_bits, 4'b0000);
    check("reset_prog_err", {3'b0, bus.prog_err}, 4'b0000);

    // NAND truth table on r15 = N(r0, r1)
    prog_write(0, 15, 1, 0);
    check("idle_write_no_err", {3'b0, bus.prog_err}, 4'b0000);
    run(4'b0011, 1, 4'b0000, "nand_11", 1'b1); wait_idle("nand_11");
    run(4'b0001, 1, 4'b1000, "nand_01", 1'b1); wait_idle("nand_01");
    run(4'b0010, 1, 4'b1000, "nand_10", 1'b1); wait_idle("nand_10");
    run(4'b0000, 1, 4'b1000, "nand_00", 1'b1); wait_idle("nand_00");

    // XOR built from four NANDs
    load_xor();
    run(4'b0000, 4, 4'b0000, "xor_00", 1'b1); wait_idle("xor_00");
    run(4'b0011, 4, 4'b0000, "xor_11", 1'b1); wait_idle("xor_11");
    run(4'b0010, 4, 4'b1000, "xor_10", 1'b1); wait_idle("xor_10");
    run(4'b0001, 4, 4'b1000, "xor_01", 1'b1); wait_idle("xor_01");

    // Zero-length program just clears the outputs
    run(4'b1111, 0, 4'b0000, "len0", 1'b1); wait_idle("len0");

    // Start and program write during EXEC are ignored; error flag set
    run(4'b0001, 4, 4'b1000, "xor_busy_poke", 1'b1);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.in_bits   = 4'b0011;
    bus.prog_len  = 6'd1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 5'd0;
    bus.prog_data = 12'hfff;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    check("prog_err_set", {3'b0, bus.prog_err}, 4'b0001);
    check("still_busy", {3'b0, bus.busy}, 4'b0001);
    wait_idle("xor_busy_poke");
    check("prog_err_sticky", {3'b0, bus.prog_err}, 4'b0001);
    run(4'b0010, 4, 4'b1000, "xor_after_poke", 1'b1);
    check("prog_err_cleared", {3'b0, bus.prog_err}, 4'b0000);
    wait_idle("xor_after_poke");

    // Overwrite an input register and read-modify-write in place
    prog_write(0, 0, 0, 0);
    prog_write(1, 15, 0, 0);
    run(4'b0001, 2, 4'b1000, "inplace_1", 1'b1); wait_idle("inplace_1");
    run(4'b0000, 2, 4'b0000, "inplace_0", 1'b1); wait_idle("inplace_0");

    // Reset in the middle of EXEC aborts the run
    load_xor();
    run(4'b0001, 4, 4'b1000, "xor_prime", 1'b1); wait_idle("xor_prime");
    run(4'b0010, 4, 4'b0000, "aborted", 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", {3'b0, bus.busy}, 4'b0000);
    check("abort_done", {3'b0, bus.done}, 4'b0000);
    check("abort_out_bits", bus.out_bits, 4'b0000);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_no_late_done", {3'b0, bus.done}, 4'b0000);
    run(4'b0010, 4, 4'b1000, "xor_after_rst", 1'b1); wait_idle("xor_after_rst");
    run(4'b0011, 4, 4'b0000, "xor_after_rst_11", 1'b1); wait_idle("xor_after_rst_11");

`ifdef NAND_SEQ_STEP_EN
    // Step on every third cycle: ops land at edges N+5, N+8, N+11, N+14
    begin
      int n0;
      @(negedge clk);
      step         = 1'b0;
      bus.start    = 1'b1;
      bus.in_bits  = 4'b0001;
      bus.prog_len = 6'd4;
      n0 = cyc;
      sb.push_back('{4'b1000, n0 + 15, "xor_step"});
      @(negedge clk);
      bus.start = 1'b0;
      for (int i = 0; i < 40 && sb.size() != 0; i++) begin
        int e;
        e = cyc + 1 - (n0 + 3);
        step = (e >= 2) && (e % 3 == 2);
        @(negedge clk);
      end
      step = 1'b1;
      wait_idle("xor_step");
    end
`endif

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
